// File: rtl/mod_arith_host.sv
// mod_arith_host: host-side front end for a wide modular-arithmetic engine.
// The host loads the operands a, b and m one word at a time, then pulses
// start. The block issues the operation to the engine, waits for the
// engine's completion pulse, and captures the engine result so the host can
// read it back one word at a time.
//
// Handshake summary: exec_p is a one-cycle request to the engine. The
// operands, sub and nbits are valid with it and stay stable until the
// engine's eng_done_p is accepted. The block accepts eng_done_p only while
// it is waiting for a result, and ignores it at any other time. Each rd_en
// in READY returns one word on rd_data, with rd_valid=1, on the next cycle.
//
// Optional feature: define MOD_ARITH_HOST_TIMEOUT_EN to add parameter TMO
// and a bounded wait. If no eng_done_p arrives within TMO cycles, the block
// sets timeout_err, stores a zero result and completes anyway.
module mod_arith_host #(
    parameter int NBITS = 2048,
    parameter int WBITS = 32
`ifdef MOD_ARITH_HOST_TIMEOUT_EN
    ,
    parameter int TMO   = 4096
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [1:0]       wr_sel,
    input  logic [WBITS-1:0] wr_data,
    input  logic             start,
    input  logic             sub_i,
    input  logic [10:0]      nbits_i,
    input  logic             rd_en,
    output logic [WBITS-1:0] rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done_irq_p,
    output logic             timeout_err,
    output logic             exec_p,
    output logic             sub,
    output logic [10:0]      nbits,
    output logic [NBITS-1:0] a,
    output logic [NBITS-1:0] b,
    output logic [NBITS-1:0] m,
    input  logic [NBITS-1:0] y,
    input  logic             eng_done_p,
    output logic [1:0]       state_dbg
);

    localparam int NW = NBITS / WBITS;
    localparam int PW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t state, next_state;

    logic [NBITS-1:0] a_q, b_q, m_q, result_q;
    logic [PW-1:0]    wptr_a, wptr_b, wptr_m, rptr;
    logic             sub_q;
    logic [10:0]      nbits_q;

    logic start_ok, wr_ok, rd_ok, done_ok, tmo_hit;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(NW - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef MOD_ARITH_HOST_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0] tmo_cnt;
    logic          tmo_err_q;

    // Count the consecutive WAIT cycles that pass without an engine response.
    always_ff @(posedge clk) begin
        if (rst || state != S_WAIT || eng_done_p) tmo_cnt <= '0;
        else                                      tmo_cnt <= tmo_cnt + 1'b1;
    end

    // Sticky timeout flag, cleared by reset or by the next accepted start.
    always_ff @(posedge clk) begin
        if (rst)           tmo_err_q <= 1'b0;
        else if (start_ok) tmo_err_q <= 1'b0;
        else if (tmo_hit)  tmo_err_q <= 1'b1;
    end

    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    // Next-state logic plus the decoded strobes that gate the datapath.
    always_comb begin
        next_state = state;
        exec_p     = 1'b0;
        busy       = 1'b0;
        start_ok   = 1'b0;
        wr_ok      = 1'b0;
        rd_ok      = 1'b0;
        done_ok    = 1'b0;
        tmo_hit    = 1'b0;
`ifdef MOD_ARITH_HOST_TIMEOUT_EN
        tmo_hit = (state == S_WAIT) && !eng_done_p && (tmo_cnt == CW'(TMO - 1));
`endif
        case (state)
            S_IDLE, S_READY: begin
                wr_ok = wr_en && (wr_sel != 2'd3);
                rd_ok = rd_en && (state == S_READY);
                if (start) begin
                    start_ok   = 1'b1;
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                exec_p     = 1'b1;
                busy       = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (eng_done_p) begin
                    done_ok    = 1'b1;
                    next_state = S_READY;
                end else if (tmo_hit) begin
                    next_state = S_READY;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Operand loading, mode latch, result capture and word readback.
    // A start clears the pointers after any same-cycle write, so a cleared
    // pointer overrides the write's increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            result_q   <= '0;
            wptr_a     <= '0;
            wptr_b     <= '0;
            wptr_m     <= '0;
            rptr       <= '0;
            sub_q      <= 1'b0;
            nbits_q    <= '0;
            done_irq_p <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
        end else begin
            if (wr_ok) begin
                case (wr_sel)
                    2'd0: begin
                        a_q[wptr_a*WBITS +: WBITS] <= wr_data;
                        wptr_a <= ptr_next(wptr_a);
                    end
                    2'd1: begin
                        b_q[wptr_b*WBITS +: WBITS] <= wr_data;
                        wptr_b <= ptr_next(wptr_b);
                    end
                    default: begin
                        m_q[wptr_m*WBITS +: WBITS] <= wr_data;
                        wptr_m <= ptr_next(wptr_m);
                    end
                endcase
            end

            if (rd_ok) begin
                rd_valid <= 1'b1;
                rd_data  <= result_q[rptr*WBITS +: WBITS];
                rptr     <= ptr_next(rptr);
            end else begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
            end

            if (start_ok) begin
                sub_q   <= sub_i;
                nbits_q <= nbits_i;
                wptr_a  <= '0;
                wptr_b  <= '0;
                wptr_m  <= '0;
                rptr    <= '0;
            end

            done_irq_p <= done_ok || tmo_hit;
            if (done_ok)      result_q <= y;
            else if (tmo_hit) result_q <= '0;
        end
    end

    assign a         = a_q;
    assign b         = b_q;
    assign m         = m_q;
    assign sub       = sub_q;
    assign nbits     = nbits_q;
    assign state_dbg = state;

endmodule

// File: doc/mod_arith_host.md
MOD_ARITH_HOST -- requirements
Module: mod_arith_host

Interface
REQ-001 SHALL have parameter NBITS, default 2048: operand/result width.
REQ-002 SHALL have parameter WBITS, default 32: host word width; NBITS is a multiple of WBITS; NW = NBITS/WBITS.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 wr_en  input  1  host operand word write strobe.
REQ-006 wr_sel  input  2  operand select: 0=a, 1=b, 2=m, 3=ignored.
REQ-007 wr_data  input  WBITS  operand word.
REQ-008 start  input  1  one-cycle operation request.
REQ-009 sub_i, nbits_i  input  1, 11  operation mode and active bit length, latched at start.
REQ-010 rd_en  input  1  result word read strobe.
REQ-011 rd_data, rd_valid  output  WBITS, 1  result word and its qualifier.
REQ-012 busy, done_irq_p, timeout_err  output  1 each  status, one-cycle completion pulse, sticky error.
REQ-013 exec_p, sub, nbits, a, b, m  output  1, 1, 11, NBITS x3  engine request side.
REQ-014 y, eng_done_p  input  NBITS, 1  engine result and completion pulse.

Function
REQ-015 SHALL implement states IDLE, ISSUE, WAIT, READY.
REQ-016 In IDLE/READY, wr_en SHALL store wr_data at word index wptr[wr_sel] (word 0 = LSBs) of the selected operand, then increment that pointer, wrapping NW-1 -> 0.
REQ-017 wr_en in ISSUE/WAIT SHALL be dropped with no register or pointer change.
REQ-018 start in IDLE/READY SHALL latch sub_i/nbits_i, clear all write and read pointers, and go to ISSUE next cycle; a wr_en in the same cycle SHALL be written before the issue, and the cleared pointer wins over its increment.
REQ-019 ISSUE SHALL assert exec_p for exactly one cycle, then go to WAIT; busy SHALL be 1 in ISSUE and WAIT only.
REQ-020 eng_done_p SHALL be honoured only in WAIT; on it y SHALL be captured into the result register, done_irq_p pulses the next cycle, and state goes to READY.
REQ-021 eng_done_p outside WAIT SHALL be ignored.
REQ-022 start in ISSUE/WAIT SHALL be ignored.
REQ-023 In READY, rd_en SHALL return result word rptr on rd_data with rd_valid=1 one cycle later, then increment rptr, wrapping NW-1 -> 0; rd_en outside READY gives rd_valid=0.
REQ-024 rd_data SHALL be 0 whenever rd_valid=0.
REQ-025 a, b, m, sub, nbits SHALL be driven continuously from internal registers and held stable from ISSUE until leaving WAIT.

Reset
REQ-026 rst SHALL, at any state including mid-operation, force IDLE, clear a, b, m, result, all pointers, sub, nbits, and drive exec_p, busy, done_irq_p, rd_valid, rd_data, timeout_err to 0.
REQ-027 An eng_done_p coincident with rst SHALL be discarded.

Configuration
REQ-028 Macro MOD_ARITH_HOST_TIMEOUT_EN SHALL, when defined, add parameter TMO (default 4096) and a WAIT-cycle counter; on reaching TMO cycles without eng_done_p, timeout_err sets (cleared only by rst or next accepted start), done_irq_p pulses, result is zero, state goes to READY.
REQ-029 Without the macro, WAIT SHALL be unbounded and timeout_err tied to 0.

Verification
REQ-030 NBITS=64,WBITS=32: write a=5,b=7,m=11 (2 words each), start sub_i=0 -> one exec_p, busy=1; engine returns y=1 after 3 cycles -> done_irq_p 1 cycle later; two reads give 1 then 0.
REQ-031 wr_en during WAIT with wr_data=FFFFFFFF -> a unchanged, engine inputs stable.
REQ-032 start and wr_en (word 0 of b = 9) in same cycle -> ISSUE sees b word0=9, all pointers 0 afterwards.
REQ-033 rst asserted in WAIT with eng_done_p same cycle -> IDLE, all outputs 0, no done_irq_p.
REQ-034 Macro defined, TMO=16, no eng_done_p -> timeout_err=1 and done_irq_p after 16 WAIT cycles, read returns 0; next start clears timeout_err.
REQ-035 Three reads in READY with NW=2 -> words 0, 1, 0 (wrap).
